// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: a bank of JK flip-flop cells shared by two requesters.
// A round-robin arbiter grants one request per two-cycle IDLE/APPLY pass.
// The winner's JK op is applied to one cell at the edge that ends APPLY.
module jk_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [1:0]       op_a,
  input  logic [IDXW-1:0]  idx_a,
  input  logic             req_b,
  input  logic [1:0]       op_b,
  input  logic [IDXW-1:0]  idx_b,
  input  logic             clr_all,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             busy,
  output logic             err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qNot
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_last_b;   // 1 when requester B holds the most recent grant
  logic              r_gnt_a;
  logic              r_gnt_b;
  logic              r_err;      // latched "index out of range" for the current grant
  logic [1:0]        r_op;
  logic [IDXW-1:0]   r_idx;
  logic [WIDTH-1:0]  r_q;

  logic              w_grant;
  logic              w_win_b;
  logic [1:0]        w_op;
  logic [IDXW-1:0]   w_idx;
  logic              w_oob;
  logic [WIDTH-1:0]  w_q_apply;

  // JK next-state for one cell: 00 hold, 01 clear, 10 set, 11 toggle
  function automatic logic jk_next(input logic [1:0] op, input logic cur);
    logic nxt;
    case (op)
      2'b01:   nxt = 1'b0;
      2'b10:   nxt = 1'b1;
      2'b11:   nxt = ~cur;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Next-state and arbitration decision; requests only matter in IDLE
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_win_b      = 1'b0;
    if (r_state == S_IDLE) begin
      if (req_a || req_b) begin
        w_grant      = 1'b1;
        // B wins when alone, or when both ask and A was granted last
        w_win_b      = req_b && (!req_a || !r_last_b);
        w_state_next = S_APPLY;
      end
    end else begin
      w_state_next = S_IDLE;
    end
  end

  // Select the winner's op and index and flag indices past the bank end
  always_comb begin
    w_op  = op_a;
    w_idx = idx_a;
    if (w_win_b) begin
      w_op  = op_b;
      w_idx = idx_b;
    end
    w_oob = (int'(w_idx) >= WIDTH);
  end

  // Per-cell candidate value: only the addressed cell takes the JK op
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    logic w_hit;
    assign w_hit         = (int'(r_idx) == gi);
    assign w_q_apply[gi] = w_hit ? jk_next(r_op, r_q[gi]) : r_q[gi];
  end

  // FSM state, latched grant info and registered grant/err pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last_b <= 1'b1;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_err    <= 1'b0;
      r_op     <= 2'b00;
      r_idx    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_last_b <= w_win_b;
        r_op     <= w_op;
        r_idx    <= w_idx;
        r_gnt_a  <= ~w_win_b;
        r_gnt_b  <= w_win_b;
        r_err    <= w_oob;
      end else begin
        r_gnt_a  <= 1'b0;
        r_gnt_b  <= 1'b0;
        r_err    <= 1'b0;
      end
    end
  end

  // Bank update: clear-all beats the APPLY write; bad indices write nothing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr_all) begin
      r_q <= '0;
    end else if ((r_state == S_APPLY) && !r_err) begin
      r_q <= w_q_apply;
    end
  end

  assign gnt_a = r_gnt_a;
  assign gnt_b = r_gnt_b;
  assign busy  = (r_state == S_APPLY);
  assign err   = r_err;
  assign q     = r_q;
  assign qNot  = ~r_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed stimulus with a scoreboard of expected grants.
// The driver pushes the expected grant/err and resulting q for every request;
// a negedge monitor pops one entry per APPLY cycle and checks q afterwards.
module tb_jk_bank_arbiter;

  typedef struct {
    logic       ga;
    logic       gb;
    logic       er;
    logic [7:0] q;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       req_a, req_b, clr_all;
  logic [1:0] op_a, op_b;
  logic [2:0] idx_a, idx_b;
  logic       gnt_a, gnt_b, busy, err;
  logic [7:0] q, qNot;

  // second bank, six cells wide, for out-of-range index handling
  logic       req_a6, req_b6, clr_all6;
  logic [1:0] op_a6, op_b6;
  logic [2:0] idx_a6, idx_b6;
  logic       gnt_a6, gnt_b6, busy6, err6;
  logic [5:0] q6, qNot6;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_txn    = 0;
  logic pend     = 1'b0;
  exp_t cur;

  jk_bank_arbiter #(.WIDTH(8), .IDXW(3)) u_dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .op_a(op_a), .idx_a(idx_a),
    .req_b(req_b), .op_b(op_b), .idx_b(idx_b),
    .clr_all(clr_all),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy), .err(err),
    .q(q), .qNot(qNot)
  );

  jk_bank_arbiter #(.WIDTH(6), .IDXW(3)) u_dut6 (
    .clk(clk), .reset(reset),
    .req_a(req_a6), .op_a(op_a6), .idx_a(idx_a6),
    .req_b(req_b6), .op_b(op_b6), .idx_b(idx_b6),
    .clr_all(clr_all6),
    .gnt_a(gnt_a6), .gnt_b(gnt_b6), .busy(busy6), .err(err6),
    .q(q6), .qNot(qNot6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input logic ga, input logic gb, input logic er, input logic [7:0] qe);
    exp_t e;
    e.ga = ga; e.gb = gb; e.er = er; e.q = qe;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: grant checks in the APPLY cycle, bank checks one cycle later
  always @(negedge clk) begin
    if (pend) begin
      pend = 1'b0;
      check("q_after", {24'd0, q}, {24'd0, cur.q});
      check("qNot_after", {24'd0, qNot}, {24'd0, ~cur.q});
      check("busy_after", {31'd0, busy}, 32'd0);
    end else if (busy === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_grant", 32'd1, 32'd0);
      end else begin
        cur = sb.pop_front();
        n_txn++;
        $display("txn %0d: gnt_a=%0b gnt_b=%0b err=%0b expect q=%02h", n_txn, gnt_a, gnt_b, err, cur.q);
        check("gnt_a", {31'd0, gnt_a}, {31'd0, cur.ga});
        check("gnt_b", {31'd0, gnt_b}, {31'd0, cur.gb});
        check("err", {31'd0, err}, {31'd0, cur.er});
        pend = 1'b1;
      end
    end
  end

  logic [2:0] set_idx [4];
  logic [7:0] set_q   [4];

  initial begin
    reset = 1'b1; clr_all = 1'b0;
    req_a = 1'b0; op_a = 2'b00; idx_a = 3'd0;
    req_b = 1'b0; op_b = 2'b00; idx_b = 3'd0;
    req_a6 = 1'b0; op_a6 = 2'b00; idx_a6 = 3'd0;
    req_b6 = 1'b0; op_b6 = 2'b00; idx_b6 = 3'd0; clr_all6 = 1'b0;
    set_idx[0] = 3'd0; set_q[0] = 8'h01;
    set_idx[1] = 3'd2; set_q[1] = 8'h05;
    set_idx[2] = 3'd5; set_q[2] = 8'h25;
    set_idx[3] = 3'd7; set_q[3] = 8'hA5;

    tick(2);
    reset = 1'b0;
    check("rst_q", {24'd0, q}, 32'h00);
    check("rst_qNot", {24'd0, qNot}, 32'hFF);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // single set on cell 3
    req_a = 1'b1; op_a = 2'b10; idx_a = 3'd3;
    push(1'b1, 1'b0, 1'b0, 8'h08);
    tick(1); req_a = 1'b0;
    tick(1);

    // B hold on cell 5 so that A wins the next contention
    req_b = 1'b1; op_b = 2'b00; idx_b = 3'd5;
    push(1'b0, 1'b1, 1'b0, 8'h08);
    tick(1); req_b = 1'b0;
    tick(1);

    // both held, toggles: alternate A,B,A,B
    req_a = 1'b1; op_a = 2'b11; idx_a = 3'd0;
    req_b = 1'b1; op_b = 2'b11; idx_b = 3'd3;
    push(1'b1, 1'b0, 1'b0, 8'h09);
    push(1'b0, 1'b1, 1'b0, 8'h01);
    push(1'b1, 1'b0, 1'b0, 8'h00);
    push(1'b0, 1'b1, 1'b0, 8'h08);
    tick(8);
    req_a = 1'b0; req_b = 1'b0;

    // clear on cell 3 overridden by clr_all on the APPLY edge
    req_b = 1'b1; op_b = 2'b01; idx_b = 3'd3;
    push(1'b0, 1'b1, 1'b0, 8'h00);
    tick(1); req_b = 1'b0; clr_all = 1'b1;
    tick(1); clr_all = 1'b0;

    // build 0xA5 with sets from A
    for (int i = 0; i < 4; i++) begin
      req_a = 1'b1; op_a = 2'b10; idx_a = set_idx[i];
      push(1'b1, 1'b0, 1'b0, set_q[i]);
      tick(1); req_a = 1'b0;
      tick(1);
    end

    // hold op on cell 5 leaves 0xA5
    req_b = 1'b1; op_b = 2'b00; idx_b = 3'd5;
    push(1'b0, 1'b1, 1'b0, 8'hA5);
    tick(1); req_b = 1'b0;
    tick(1);

    // clr_all in IDLE does not block the grant at the same edge
    req_a = 1'b1; op_a = 2'b10; idx_a = 3'd1; clr_all = 1'b1;
    push(1'b1, 1'b0, 1'b0, 8'h02);
    tick(1); req_a = 1'b0; clr_all = 1'b0;
    tick(1);

    // reset during APPLY aborts the pending set on cell 6
    req_a = 1'b1; op_a = 2'b10; idx_a = 3'd6;
    push(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1); req_a = 1'b0; reset = 1'b1;
    tick(1); reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
    tick(3);
    check("abort_q_later", {24'd0, q}, 32'h00);

    // six-cell bank: index 7 is out of range
    req_a6 = 1'b1; op_a6 = 2'b10; idx_a6 = 3'd7;
    tick(1); req_a6 = 1'b0;
    $display("w6 txn idx=7: gnt_a=%0b err=%0b busy=%0b", gnt_a6, err6, busy6);
    check("w6_oob_gnt", {31'd0, gnt_a6}, 32'd1);
    check("w6_oob_err", {31'd0, err6}, 32'd1);
    check("w6_oob_busy", {31'd0, busy6}, 32'd1);
    tick(1);
    check("w6_oob_q", {26'd0, q6}, 32'h00);
    check("w6_oob_err_off", {31'd0, err6}, 32'd0);

    // index 5 is the last valid cell
    req_a6 = 1'b1; op_a6 = 2'b10; idx_a6 = 3'd5;
    tick(1); req_a6 = 1'b0;
    $display("w6 txn idx=5: gnt_a=%0b err=%0b", gnt_a6, err6);
    check("w6_last_err", {31'd0, err6}, 32'd0);
    tick(1);
    check("w6_last_q", {26'd0, q6}, 32'h20);

    // index 6 equals WIDTH: out of range, q unchanged
    req_a6 = 1'b1; op_a6 = 2'b11; idx_a6 = 3'd6;
    tick(1); req_a6 = 1'b0;
    $display("w6 txn idx=6: gnt_a=%0b err=%0b", gnt_a6, err6);
    check("w6_edge_err", {31'd0, err6}, 32'd1);
    tick(1);
    check("w6_edge_q", {26'd0, q6}, 32'h20);
    check("w6_edge_qNot", {26'd0, qNot6}, 32'h1F);

    tick(3);
    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: number of JK flip-flop cells in the bank.
REQ-002 Parameter IDXW, default 3: width of the cell index fields.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port req_a, input, 1: requester A request.
REQ-006 Port op_a, input, 2: requester A JK code {j,k}: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-007 Port idx_a, input, IDXW: requester A target cell.
REQ-008 Ports req_b, op_b, idx_b: requester B request, op code and index; same widths and meanings as requester A.
REQ-009 Port clr_all, input, 1: synchronous bank clear request.
REQ-010 Port gnt_a, output, 1: one-cycle grant to requester A.
REQ-011 Port gnt_b, output, 1: one-cycle grant to requester B.
REQ-012 Port busy, output, 1: high while state is APPLY.
REQ-013 Port err, output, 1: one-cycle pulse marking a granted index >= WIDTH.
REQ-014 Port q, output, WIDTH: bank contents.
REQ-015 Port qNot, output, WIDTH: bitwise complement of q, combinational.

Function
REQ-016 The block SHALL implement a two-state FSM, IDLE and APPLY; every transition is on the rising edge of clk.
REQ-017 IDLE: with req_a or req_b high at the edge, the block SHALL latch winner, op and idx, and move to APPLY; with neither high it stays in IDLE.
REQ-018 APPLY: the block SHALL update the bank at the edge ending APPLY, then unconditionally return to IDLE.
REQ-019 Each grant therefore takes 2 cycles, and at most one grant occurs every 2 cycles.
REQ-020 gnt_a/gnt_b SHALL be registered, and high only during APPLY for the latched winner; at most one is high at a time.
REQ-021 busy SHALL equal (state == APPLY).
REQ-022 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins.
REQ-023 A single request SHALL win regardless of history.
REQ-024 The last-winner register SHALL update only on a grant.
REQ-025 Requests SHALL be sampled only in IDLE; requests held during APPLY are neither lost nor double-counted.
REQ-026 A request still high at the first IDLE edge after its grant SHALL be treated as a new request.
REQ-027 Update of q[idx] at the end of APPLY SHALL follow JK semantics: 00 hold, 01 q=0, 10 q=1, 11 q=~q.
REQ-028 All other cells SHALL be unchanged by an update.
REQ-029 When latched idx >= WIDTH, the block SHALL leave q unchanged and pulse err for the APPLY cycle.
REQ-030 err SHALL be 0 at all other times.
REQ-031 clr_all high at an edge SHALL force q to all zeros; this overrides any APPLY update at that edge.
REQ-032 The grant in progress SHALL still complete (gnt pulse, return to IDLE), with its op discarded.
REQ-033 clr_all high in IDLE SHALL NOT block arbitration at the same edge.
REQ-034 No output SHALL ever be X/Z after reset.

Reset
REQ-035 reset high at an edge SHALL set: state IDLE, q all 0, gnt_a 0, gnt_b 0, busy 0, err 0, and last-winner = B (A wins first contention).
REQ-036 reset SHALL take priority over clr_all and over any request.
REQ-037 reset asserted during APPLY SHALL abort the pending update without a grant completing its op.

Verification
REQ-038 Reset, then req_a=1, op_a=10, idx_a=3 for one edge -> gnt_a high the next cycle; q=0x08 after the following edge; busy high for exactly 1 cycle.
REQ-039 q=0x08, req_a and req_b held high, both op=11, idx_a=0, idx_b=3 -> grants alternate A,B,A,B every 2 cycles; q sequence 0x09, 0x01, 0x00, 0x08.
REQ-040 req_b=1, op_b=01, idx_b=3 with q=0x08 and clr_all=1 on the APPLY edge -> q=0x00, gnt_b pulses once, next state IDLE.
REQ-041 WIDTH=6, req_a=1, idx_a=7, op_a=10 -> err=1 during APPLY with gnt_a; q unchanged.
REQ-042 Reset asserted in APPLY of a set op on cell 1 -> q=0x00, gnt and busy 0 the next cycle; no later update.
REQ-043 op=00 grant on cell 5 with q=0xA5 -> q stays 0xA5; qNot=0x5A throughout.
